// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: operand width defaults,
// ALU opcode encodings and the multiplier FSM state encoding.
package pipe_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;
   localparam int OP_W    = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'h00;
   localparam logic [OP_W-1:0] OP_SUB = 6'h01;
   localparam logic [OP_W-1:0] OP_AND = 6'h02;
   localparam logic [OP_W-1:0] OP_OR  = 6'h03;
   localparam logic [OP_W-1:0] OP_XOR = 6'h04;
   localparam logic [OP_W-1:0] OP_NOR = 6'h05;
   localparam logic [OP_W-1:0] OP_SLT = 6'h06;
   localparam logic [OP_W-1:0] OP_SLL = 6'h07;
   localparam logic [OP_W-1:0] OP_SRL = 6'h08;
   localparam logic [OP_W-1:0] OP_SRA = 6'h09;
   localparam logic [OP_W-1:0] OP_MUL = 6'h0A;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mul_state_t;

endpackage

// File: rtl/s3_execute_if.sv
// Bus between the ID/EX register (S2), the execute stage and write-back.
//   RD1EX/RD2EX/ImmEX/DSEX/ALUEX/WSP/WEP : instruction fields from S2
//   ALUOutWB/WSWB/WEWB                   : registered EX/WB contents
//   stall                                : hold S2 and earlier stages
//   mul_busy                             : multiplier iterating
// master = S2/write-back side, slave = the execute stage.
interface s3_execute_if #(parameter int DATA_W = pipe_pkg::DATA_W);
   import pipe_pkg::*;

   logic [DATA_W-1:0] RD1EX;
   logic [DATA_W-1:0] RD2EX;
   logic [DATA_W-1:0] ImmEX;
   logic              DSEX;
   logic [OP_W-1:0]   ALUEX;
   logic [4:0]        WSP;
   logic              WEP;
   logic [DATA_W-1:0] ALUOutWB;
   logic [4:0]        WSWB;
   logic              WEWB;
   logic              stall;
   logic              mul_busy;

   modport master (
      output RD1EX, RD2EX, ImmEX, DSEX, ALUEX, WSP, WEP,
      input  ALUOutWB, WSWB, WEWB, stall, mul_busy
   );

   modport slave (
      input  RD1EX, RD2EX, ImmEX, DSEX, ALUEX, WSP, WEP,
      output ALUOutWB, WSWB, WEWB, stall, mul_busy
   );

endinterface

// File: rtl/s3_execute_seq_multiplier.sv
// Shift-add multiplier, one partial product per clock, DATA_W iterations.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : level; sampled only in IDLE
//   a, b           : operands latched on start
//   ws_in, we_in   : write-back tag carried alongside the operation
//   busy           : FSM in RUN
//   done           : one-cycle pulse on the last iteration
//   product        : final sum, valid while done is high
//   ws_out, we_out : write-back tag latched on start
//
// state | meaning
// IDLE  | waiting for start; operands load on the start edge
// RUN   | one shift-add per clock; last iteration raises done
module seq_multiplier
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [4:0]        ws_in,
   input  logic              we_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product,
   output logic [4:0]        ws_out,
   output logic              we_out
);

   localparam int              CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   mul_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] m_a;
   logic [DATA_W-1:0] m_b;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_next;
   logic [4:0]        ws_q;
   logic              we_q;

   assign acc_next = acc + (m_b[0] ? m_a : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         m_a   <= '0;
         m_b   <= '0;
         acc   <= '0;
         ws_q  <= '0;
         we_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  m_a   <= a;
                  m_b   <= b;
                  acc   <= '0;
                  cnt   <= '0;
                  ws_q  <= ws_in;
                  we_q  <= we_in;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc <= acc_next;
               m_a <= m_a << 1;
               m_b <= m_b >> 1;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (state == ST_RUN);
   assign done    = busy && (cnt == LAST);
   // The final product is the sum including the last partial product,
   // which the EX/WB register captures on the same edge that retires RUN.
   assign product = acc_next;
   assign ws_out  = ws_q;
   assign we_out  = we_q;

endmodule

// File: rtl/s3_execute.sv
// Execute stage: selects operand B, evaluates the ALU, and registers the
// result with its write-back tag into the EX/WB register. MUL runs on the
// sequential multiplier while stall holds the upstream pipeline.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : s3_execute_if slave (S2 fields in, EX/WB fields, stall,
//              mul_busy out)
module s3_execute
   import pipe_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input logic         clk,
   input logic         rst,
   s3_execute_if.slave bus
);

   logic [DATA_W-1:0]  op_b;
   logic [SHAMT_W-1:0] shamt;
   logic [DATA_W-1:0]  alu_res;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [DATA_W-1:0]  mul_prod;
   logic [4:0]         mul_ws;
   logic               mul_we;
   logic [DATA_W-1:0]  out_q;
   logic [4:0]         ws_q;
   logic               we_q;

   assign op_b  = bus.DSEX ? bus.ImmEX : bus.RD2EX;
   assign shamt = op_b[SHAMT_W-1:0];

   always_comb begin
      alu_res = '0;
      case (bus.ALUEX)
         OP_ADD: alu_res = bus.RD1EX + op_b;
         OP_SUB: alu_res = bus.RD1EX - op_b;
         OP_AND: alu_res = bus.RD1EX & op_b;
         OP_OR:  alu_res = bus.RD1EX | op_b;
         OP_XOR: alu_res = bus.RD1EX ^ op_b;
         OP_NOR: alu_res = ~(bus.RD1EX | op_b);
         OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.RD1EX) < $signed(op_b))};
         OP_SLL: alu_res = bus.RD1EX << shamt;
         OP_SRL: alu_res = bus.RD1EX >> shamt;
         OP_SRA: alu_res = DATA_W'($signed(bus.RD1EX) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   // The held S2 contents are ignored while the multiplier runs, so a MUL
   // sitting in S2 only starts the unit from IDLE.
   assign mul_start = !mul_busy && (bus.ALUEX == OP_MUL);

   seq_multiplier #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.RD1EX),
      .b       (op_b),
      .ws_in   (bus.WSP),
      .we_in   (bus.WEP),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod),
      .ws_out  (mul_ws),
      .we_out  (mul_we)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         ws_q  <= '0;
         we_q  <= 1'b0;
      end else if (mul_done) begin
         out_q <= mul_prod;
         ws_q  <= mul_ws;
         we_q  <= mul_we && (mul_ws != 5'd0);
      end else if (mul_busy || mul_start) begin
         out_q <= '0;
         ws_q  <= '0;
         we_q  <= 1'b0;
      end else begin
         out_q <= alu_res;
         ws_q  <= bus.WSP;
         we_q  <= bus.WEP && (bus.WSP != 5'd0);
      end
   end

   // Released on the last iteration so S2 advances on the retiring edge;
   // reset discards any MUL, so nothing is held while rst is asserted.
   assign bus.stall    = !rst && (mul_start || (mul_busy && !mul_done));
   assign bus.mul_busy = mul_busy;
   assign bus.ALUOutWB = out_q;
   assign bus.WSWB     = ws_q;
   assign bus.WEWB     = we_q;

endmodule

// File: tb/tb_s3_execute.sv
module tb_s3_execute;
   import pipe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   s3_execute_if #(.DATA_W(32)) bus();

   s3_execute #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        ds;
      logic [4:0]  ws;
      logic        we;
      logic [31:0] exp_out;
      logic [4:0]  exp_ws;
      logic        exp_we;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference ALU built from the arithmetic definition of each opcode.
   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      int          sh;
      sh = int'(b[4:0]);
      case (op)
         6'h00: return a + b;
         6'h01: return a - b;
         6'h02: return a & b;
         6'h03: return a | b;
         6'h04: return a ^ b;
         6'h05: return ~(a | b);
         6'h06: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h07: return a << sh;
         6'h08: return a >> sh;
         6'h09: return a[31] ? ~((~a) >> sh) : (a >> sh);
         6'h0A: begin
            p = {32'd0, a} * {32'd0, b};
            return p[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic ds, input logic [4:0] ws,
                        input logic we);
      bus.ALUEX = op;
      bus.RD1EX = a;
      bus.RD2EX = rd2;
      bus.ImmEX = imm;
      bus.DSEX  = ds;
      bus.WSP   = ws;
      bus.WEP   = we;
   endtask

   task automatic drive_garbage();
      drive(6'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
   endtask

   // Called one time unit after a posedge; returns one time unit after the next.
   task automatic single(input string tag, input vec_t v);
      drive(v.op, v.a, v.rd2, v.imm, v.ds, v.ws, v.we);
      #1;
      chk({tag, " stall"}, 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " out"}, bus.ALUOutWB, v.exp_out);
      chk({tag, " ws"},  32'(bus.WSWB), 32'(v.exp_ws));
      chk({tag, " we"},  32'(bus.WEWB), 32'(v.exp_we));
   endtask

   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] rd2,
                          input logic [31:0] imm, input logic ds, input logic [4:0] ws,
                          input logic we);
      logic [31:0] exp;
      int          n;
      int          bad;
      int          busy_bad;
      exp      = ref_alu(OP_MUL, a, ds ? imm : rd2);
      n        = 0;
      bad      = 0;
      busy_bad = 0;
      drive(OP_MUL, a, rd2, imm, ds, ws, we);
      #1;
      for (int i = 0; i < 40; i++) begin
         if (bus.stall !== 1'b1) break;
         n++;
         @(posedge clk);
         #1;
         if (bus.WEWB !== 1'b0 || bus.ALUOutWB !== 32'd0 || bus.WSWB !== 5'd0) bad++;
         if (bus.mul_busy !== 1'b1) busy_bad++;
         drive_garbage();
         #1;
      end
      chk({tag, " stall_cycles"}, 32'(n), 32'd32);
      chk({tag, " bubbles"}, 32'(bad), 32'd0);
      chk({tag, " busy_in_run"}, 32'(busy_bad), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " out"}, bus.ALUOutWB, exp);
      chk({tag, " ws"},  32'(bus.WSWB), 32'(ws));
      chk({tag, " we"},  32'(bus.WEWB), 32'(we && (ws != 5'd0)));
      chk({tag, " busy_after"}, 32'(bus.mul_busy), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   bad;

      // Directed single-cycle vectors: op, a, rd2, imm, ds, ws, we, out, ws, we
      vecs[0]  = '{6'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,  1'b0, 5'd3,  1'b1, 32'h0000_0000, 5'd3,  1'b1};
      vecs[1]  = '{6'h06, 32'hFFFF_FFFF, 32'h0,         32'h1,  1'b1, 5'd4,  1'b1, 32'h0000_0001, 5'd4,  1'b1};
      vecs[2]  = '{6'h09, 32'h8000_0000, 32'h4,         32'h0,  1'b0, 5'd5,  1'b1, 32'hF800_0000, 5'd5,  1'b1};
      vecs[3]  = '{6'h01, 32'h5,         32'h3,         32'h0,  1'b0, 5'd0,  1'b1, 32'h0000_0002, 5'd0,  1'b0};
      vecs[4]  = '{6'h02, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0,  1'b0, 5'd6,  1'b1, 32'h00F0_1200, 5'd6,  1'b1};
      vecs[5]  = '{6'h03, 32'hF000_0000, 32'h0,         32'hF,  1'b1, 5'd7,  1'b1, 32'hF000_000F, 5'd7,  1'b1};
      vecs[6]  = '{6'h04, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h0,  1'b0, 5'd8,  1'b1, 32'h5555_AAAA, 5'd8,  1'b1};
      vecs[7]  = '{6'h05, 32'h0000_00FF, 32'h0000_FF00, 32'h0,  1'b0, 5'd9,  1'b1, 32'hFFFF_0000, 5'd9,  1'b1};
      vecs[8]  = '{6'h07, 32'h1,         32'h1F,        32'h24, 1'b1, 5'd10, 1'b1, 32'h0000_0010, 5'd10, 1'b1};
      vecs[9]  = '{6'h08, 32'h8000_0000, 32'h1F,        32'h0,  1'b0, 5'd11, 1'b1, 32'h0000_0001, 5'd11, 1'b1};
      vecs[10] = '{6'h3F, 32'h5,         32'h6,         32'h0,  1'b0, 5'd12, 1'b1, 32'h0000_0000, 5'd12, 1'b1};
      vecs[11] = '{6'h06, 32'h1,         32'hFFFF_FFFF, 32'h0,  1'b0, 5'd13, 1'b1, 32'h0000_0000, 5'd13, 1'b1};
      vecs[12] = '{6'h00, 32'h10,        32'h20,        32'h0,  1'b0, 5'd14, 1'b0, 32'h0000_0030, 5'd14, 1'b0};
      vecs[13] = '{6'h01, 32'h0,         32'h1,         32'h0,  1'b0, 5'd31, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b1};

      // Reset with garbage inputs (non-MUL opcode)
      rst = 1'b1;
      drive(6'h2A, $urandom, $urandom, $urandom, 1'b1, 5'd17, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset out",   bus.ALUOutWB, 32'd0);
      chk("reset ws",    32'(bus.WSWB), 32'd0);
      chk("reset we",    32'(bus.WEWB), 32'd0);
      chk("reset stall", 32'(bus.stall), 32'd0);
      chk("reset busy",  32'(bus.mul_busy), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) single($sformatf("vec%0d", i), vecs[i]);

      // MUL cases, back to back, followed by an ADD that must not bubble
      run_mul("mul_basic", 32'h0001_2345, 32'h0000_0100, 32'h0, 1'b0, 5'd7, 1'b1);
      v = '{6'h00, 32'h1, 32'h2, 32'h0, 1'b0, 5'd2, 1'b1, 32'h3, 5'd2, 1'b1};
      single("add_after_mul", v);
      run_mul("mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd8, 1'b1);
      run_mul("mul_b2b_imm", 32'h0000_0003, 32'hDEAD_BEEF, 32'h0000_0007, 1'b1, 5'd9, 1'b1);
      run_mul("mul_r0", 32'h0000_1234, 32'h0000_0010, 32'h0, 1'b0, 5'd0, 1'b1);
      for (int i = 0; i < 4; i++)
         run_mul($sformatf("mul_rand%0d", i), pick(), pick(), $urandom, 1'($urandom),
                 5'($urandom), 1'($urandom));

      // Randomized single-cycle ops
      for (int i = 0; i < 150; i++) begin
         v.op = 6'($urandom_range(0, 15));
         if (v.op == OP_MUL) v.op = 6'h3C;
         v.a   = pick();
         v.rd2 = pick();
         v.imm = pick();
         v.ds  = 1'($urandom);
         v.ws  = 5'($urandom);
         v.we  = 1'($urandom);
         v.exp_out = ref_alu(v.op, v.a, v.ds ? v.imm : v.rd2);
         v.exp_ws  = v.ws;
         v.exp_we  = v.we && (v.ws != 5'd0);
         single($sformatf("rand%0d op%0h", i, v.op), v);
      end

      // Reset in the middle of a MUL (cnt = 10)
      drive(OP_MUL, 32'h3, 32'h5, 32'h0, 1'b0, 5'd2, 1'b1);
      repeat (11) @(posedge clk);
      #1;
      chk("midrst busy_before", 32'(bus.mul_busy), 32'd1);
      chk("midrst stall_before", 32'(bus.stall), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst out",  bus.ALUOutWB, 32'd0);
      chk("midrst ws",   32'(bus.WSWB), 32'd0);
      chk("midrst we",   32'(bus.WEWB), 32'd0);
      chk("midrst busy", 32'(bus.mul_busy), 32'd0);
      rst = 1'b0;
      v = '{6'h00, 32'd10, 32'd20, 32'h0, 1'b0, 5'd4, 1'b1, 32'd30, 5'd4, 1'b1};
      single("midrst add", v);
      bad = 0;
      drive(OP_ADD, 32'h1, 32'h1, 32'h0, 1'b0, 5'd6, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.WEWB !== 1'b0 || bus.stall !== 1'b0 || bus.mul_busy !== 1'b0) bad++;
      end
      chk("midrst no_writeback", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/s3_execute.md
Name: s3_execute

Overview:
- Execute stage, directly downstream of the S2 (ID/EX) register.
- Consumes RD1EX, RD2EX, ImmEX, DSEX, ALUEX, WSP and WEP, and computes the ALU result.
- Registers the result with its write-back control into the S3 (EX/WB) pipeline register.
- Most ops are single-cycle. MUL is a 32-iteration shift-add unit that stalls upstream while it runs.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- RD1EX  in  DATA_W  operand A.
- RD2EX  in  DATA_W  register operand B.
- ImmEX  in  DATA_W  immediate operand.
- DSEX  in  1  B-source select: 1 = ImmEX, 0 = RD2EX.
- ALUEX  in  6  ALU opcode.
- WSP  in  5  destination register index.
- WEP  in  1  register write enable.
- ALUOutWB  out  DATA_W  registered result.
- WSWB  out  5  registered destination index.
- WEWB  out  1  registered write enable.
- stall  out  1  combinational; while high, S2 and all earlier stages hold their contents.
- mul_busy  out  1  registered; high while the FSM is in RUN.

Behaviour:
- Reset: when rst=1 at posedge, ALUOutWB=0, WSWB=0, WEWB=0, FSM=IDLE, iteration count=0, internal multiplier registers=0. rst overrides everything, including a MUL in progress, which is discarded with no write-back.
- Operand B = DSEX ? ImmEX : RD2EX.
- Opcodes (6-bit, unsigned wrap arithmetic, no overflow flags):
  - 0x00 ADD; 0x01 SUB.
  - 0x02 AND; 0x03 OR; 0x04 XOR; 0x05 NOR.
  - 0x06 SLT: signed compare, result 1 or 0.
  - 0x07 SLL, 0x08 SRL, 0x09 SRA: shift amount = B[SHAMT_W-1:0].
  - 0x0A MUL: low DATA_W bits of A*B.
  - Any other opcode: result 0, write enable still propagates.
- Write-enable gating: WEWB <= WEP && (WSP != 0). Writes to r0 are suppressed.
- Single-cycle ops (FSM IDLE, opcode not MUL): stall=0. At the posedge, ALUOutWB/WSWB/WEWB load the result. Latency 1.
- MUL FSM, states IDLE and RUN:
  - IDLE with ALUEX=MUL: stall=1. At the posedge, latch mA=A, mB=B, acc=0, saved WS/WE, cnt=0; go to RUN. S3 loads a bubble (ALUOutWB=0, WSWB=0, WEWB=0).
  - RUN: each posedge does one iteration: acc += mB[0] ? mA : 0; mA <<= 1; mB >>= 1; cnt++.
  - RUN with cnt 0..30: stall=1; S3 loads a bubble each cycle.
  - RUN with cnt=31: stall=0. At that posedge the final sum loads ALUOutWB, the saved WS/WE (r0-gated) load WSWB/WEWB, and the FSM returns to IDLE. S2 advances to the next instruction on the same edge.
  - Inputs are ignored during RUN; the held S2 contents are not re-decoded.
  - Totals: stall high for 32 cycles; result visible after the 33rd posedge from first presentation.
- Back-to-back MUL: the next MUL enters IDLE→RUN on the cycle after the previous result. No overlap.
- mul_busy = (state == RUN).

Decomposition:
- Shared package pipe_pkg holds:
  - opcode localparams (OP_ADD … OP_MUL);
  - DATA_W default;
  - FSM state encoding (IDLE=0, RUN=1).
- One sub-module: seq_multiplier. It owns the FSM, counter, mA/mB/acc and the start/done handshake.
  - start is a level input; done is a one-cycle pulse coinciding with cnt=31.
  - Combinational ALU and S3 register stay in s3_execute.

Test Plan:
- Reset: drive garbage inputs with rst=1 for 2 cycles → ALUOutWB=0, WSWB=0, WEWB=0, stall=0, mul_busy=0.
- Single-cycle ops:
  - ADD A=0xFFFFFFFF, B=1 (DSEX=0), WSP=3, WEP=1 → next cycle ALUOutWB=0, WSWB=3, WEWB=1.
  - SLT A=0xFFFFFFFF, ImmEX=1, DSEX=1 → ALUOutWB=1.
  - SRA A=0x80000000, B=4 → ALUOutWB=0xF8000000.
- r0 suppression: SUB A=5, B=3, WSP=0, WEP=1 → ALUOutWB=2, WEWB=0.
- MUL: A=0x00012345, B=0x00000100, WSP=7, WEP=1 →
  - stall high exactly 32 cycles; 32 bubbles with WEWB=0;
  - then ALUOutWB=0x01234500, WSWB=7, WEWB=1;
  - the following ADD issues with no extra bubble.
- MUL wrap: A=0xFFFFFFFF, B=0xFFFFFFFF → ALUOutWB=0x00000001.
- Reset mid-MUL: assert rst at cnt=10 → outputs zero, stall=0, mul_busy=0 next cycle, no write-back. A new ADD then completes in 1 cycle.
